fpu_cmp_sched: RTL and testbench

Two-requester scheduler and sequencer for the shared single-precision floating-point compare datapath. It arbitrates round-robin between two requesters, such as the integer-issue path and the branch/predicate path. It classifies both operands and evaluates FEQ/FLT/FLE with IEEE-754 NaN and signed-zero rules. It returns a registered result with a per-request invalid flag, and keeps sticky exception flags for the FPU CSR.

---
 rtl/FPU_class_types.sv | 53 +++++
 rtl/fpu_cmp_core.sv | 67 ++++++
 rtl/fpu_cmp_sched.sv | 144 ++++++++++++++
 tb/tb_fpu_cmp_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/FPU_class_types.sv
`default_nettype none
// ============================================================================
//  Module      : FPU_class_types (package)
//  Description : Shared operand-class encoding, compare opcodes, scheduler
//                states and flag indices for the FP compare datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package FPU_class_types;

    // One-hot operand class; bit order follows the FCLASS result layout
    typedef enum logic [9:0] {
        CLS_NEG_INF  = 10'b00_0000_0001,
        CLS_NEG_NORM = 10'b00_0000_0010,
        CLS_NEG_SUB  = 10'b00_0000_0100,
        CLS_NEG_ZERO = 10'b00_0000_1000,
        CLS_POS_ZERO = 10'b00_0001_0000,
        CLS_POS_SUB  = 10'b00_0010_0000,
        CLS_POS_NORM = 10'b00_0100_0000,
        CLS_POS_INF  = 10'b00_1000_0000,
        CLS_SNAN     = 10'b01_0000_0000,
        CLS_QNAN     = 10'b10_0000_0000
    } fp_class_t;

    typedef enum logic [2:0] {
        CMP_LE = 3'b000,
        CMP_LT = 3'b001,
        CMP_EQ = 3'b010
    } cmp_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } sched_state_t;

    localparam int FFLAG_NV = 4;

    function automatic fp_class_t fp_classify(input logic [31:0] x);
        fp_class_t cls;
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0) cls = x[31] ? CLS_NEG_INF : CLS_POS_INF;
            else                  cls = x[22] ? CLS_QNAN : CLS_SNAN;
        end else if (x[30:23] == 8'h00) begin
            if (x[22:0] == 23'd0) cls = x[31] ? CLS_NEG_ZERO : CLS_POS_ZERO;
            else                  cls = x[31] ? CLS_NEG_SUB : CLS_POS_SUB;
        end else begin
            cls = x[31] ? CLS_NEG_NORM : CLS_POS_NORM;
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_cmp_core.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_cmp_core
//  Description : Combinational single-precision FEQ/FLT/FLE evaluation with
//                operand classification and invalid-operation detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_cmp_core
    import FPU_class_types::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output fp_class_t   class_a,
    output fp_class_t   class_b,
    output logic        result,
    output logic        nv,
    output logic        err
);

    logic w_nan_any;
    logic w_snan_any;
    logic w_both_zero;
    logic w_eq;
    logic w_lt;

    assign class_a = fp_classify(a);
    assign class_b = fp_classify(b);

    assign w_nan_any   = (class_a == CLS_QNAN) || (class_a == CLS_SNAN) ||
                         (class_b == CLS_QNAN) || (class_b == CLS_SNAN);
    assign w_snan_any  = (class_a == CLS_SNAN) || (class_b == CLS_SNAN);
    assign w_both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    assign w_eq        = w_both_zero || (a == b);

    // Sign-magnitude ordering; NaNs are masked off when the result is formed
    always_comb begin
        w_lt = 1'b0;
        if (w_both_zero)         w_lt = 1'b0;
        else if (a[31] != b[31]) w_lt = a[31];
        else if (!a[31])         w_lt = (a[30:0] < b[30:0]);
        else                     w_lt = (a[30:0] > b[30:0]);
    end

    always_comb begin
        result = 1'b0;
        nv     = 1'b0;
        err    = 1'b0;
        case (op)
            CMP_LE: begin
                result = !w_nan_any && (w_lt || w_eq);
                nv     = w_nan_any;
            end
            CMP_LT: begin
                result = !w_nan_any && w_lt;
                nv     = w_nan_any;
            end
            CMP_EQ: begin
                result = !w_nan_any && w_eq;
                nv     = w_snan_any;
            end
            default: err = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fpu_cmp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_cmp_sched
//  Description : Two-requester round-robin scheduler for the shared FP compare
//                datapath with registered response and sticky FPU flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_cmp_sched
    import FPU_class_types::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [63:0]          req_a,
    input  logic [63:0]          req_b,
    input  logic [5:0]           req_op,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [TAG_W-1:0]     resp_tag,
    output logic                 resp_result,
    output logic [4:0]           resp_fflags,
    output logic                 resp_err,
    input  logic                 fflags_clr,
    output logic [4:0]           fflags_sticky
);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic              r_rr_ptr;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [2:0]        r_op;
    logic [TAG_W-1:0]  r_tag;
    logic              r_id;

    logic              w_grant;
    logic              w_req_hs;
    logic              w_resp_hs;
    fp_class_t         w_class_a;
    fp_class_t         w_class_b;
    logic              w_result;
    logic              w_nv;
    logic              w_err;
    logic [4:0]        w_fflags;
    logic              w_unused_class;

    // Lone requester wins outright; contention goes to the pointer
    assign w_grant   = (req_valid == 2'b11) ? r_rr_ptr : req_valid[1];
    assign w_resp_hs = (r_state == ST_RESP) && resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        w_req_hs    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready   = w_grant ? 2'b10 : 2'b01;
                    w_req_hs    = 1'b1;
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: w_state_nxt = ST_RESP;
            ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_tag    <= '0;
            r_id     <= 1'b0;
        end else if (w_req_hs) begin
            r_rr_ptr <= ~w_grant;
            r_a      <= w_grant ? req_a[63:32] : req_a[31:0];
            r_b      <= w_grant ? req_b[63:32] : req_b[31:0];
            r_op     <= w_grant ? req_op[5:3]  : req_op[2:0];
            r_tag    <= w_grant ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
            r_id     <= w_grant;
        end
    end

    fpu_cmp_core u_core (
        .a       (r_a),
        .b       (r_b),
        .op      (r_op),
        .class_a (w_class_a),
        .class_b (w_class_b),
        .result  (w_result),
        .nv      (w_nv),
        .err     (w_err)
    );

    // Classes are exported by the core for other consumers; not needed here
    assign w_unused_class = ^{w_class_a, w_class_b};

    always_comb begin
        w_fflags           = 5'd0;
        w_fflags[FFLAG_NV] = w_nv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_tag    <= '0;
            resp_result <= 1'b0;
            resp_fflags <= 5'd0;
            resp_err    <= 1'b0;
        end else if (r_state == ST_EVAL) begin
            resp_valid  <= 1'b1;
            resp_id     <= r_id;
            resp_tag    <= r_tag;
            resp_result <= w_result;
            resp_fflags <= w_fflags;
            resp_err    <= w_err;
        end else if (w_resp_hs) begin
            resp_valid  <= 1'b0;
        end
    end

    // A same-cycle clear loses to the flags being delivered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          fflags_sticky <= 5'd0;
        else if (w_resp_hs)  fflags_sticky <= (fflags_clr ? 5'd0 : fflags_sticky) | resp_fflags;
        else if (fflags_clr) fflags_sticky <= 5'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_cmp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_cmp_sched
//  Description : Directed self-checking bench for the FP compare scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_cmp_sched;

    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [63:0]       req_a = '0;
    logic [63:0]       req_b = '0;
    logic [5:0]        req_op = '0;
    logic [2*TAG_W-1:0] req_tag = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic              resp_id;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_result;
    logic [4:0]        resp_fflags;
    logic              resp_err;
    logic              fflags_clr = 1'b0;
    logic [4:0]        fflags_sticky;

    int n_chk = 0;
    int n_err = 0;

    fpu_cmp_sched #(.TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .req_tag       (req_tag),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_tag      (resp_tag),
        .resp_result   (resp_result),
        .resp_fflags   (resp_fflags),
        .resp_err      (resp_err),
        .fflags_clr    (fflags_clr),
        .fflags_sticky (fflags_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [3:0] tag);
        req_a[32*id +: 32]     = a;
        req_b[32*id +: 32]     = b;
        req_op[3*id +: 3]      = op;
        req_tag[TAG_W*id +: 4] = tag;
    endtask

    // One full request/response; response consumed with resp_ready high
    task automatic txn(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [3:0] tag,
                       input logic e_res, input logic e_nv, input logic e_err,
                       input logic clr, input logic [4:0] e_st);
        int n;
        @(negedge clk);
        set_req(id, a, b, op, tag);
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("hs_timeout", 32'(n >= 20), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
        chk("eval_not_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_result", 32'(resp_result), 32'(e_res));
        chk("resp_fflags", 32'(resp_fflags), 32'({e_nv, 4'b0000}));
        chk("resp_err", 32'(resp_err), 32'(e_err));
        chk("resp_id", 32'(resp_id), 32'(id));
        chk("resp_tag", 32'(resp_tag), 32'(tag));
        fflags_clr = clr;
        @(negedge clk);
        fflags_clr = 1'b0;
        chk("resp_drop", 32'(resp_valid), 32'd0);
        chk("sticky", 32'(fflags_sticky), 32'(e_st));
    endtask

    initial begin
        int g_cnt;
        int g_id[4];
        int g_cyc[4];
        int n;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        chk("rst_tag", 32'(resp_tag), 32'd0);
        chk("rst_result", 32'(resp_result), 32'd0);
        chk("rst_fflags", 32'(resp_fflags), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_sticky", 32'(fflags_sticky), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b11; #1;
        chk("rst_rr_grant", 32'(req_ready), 32'd1);
        req_valid = 2'b10; #1;
        chk("single_grant1", 32'(req_ready), 32'd2);
        req_valid = 2'b00;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        //   id a             b             op      tag   res nv err clr sticky
        txn(0, 32'h3F800000, 32'h40000000, 3'b001, 4'd3, 1, 0, 0, 0, 5'b00000);
        txn(0, 32'h80000000, 32'h00000000, 3'b010, 4'd4, 1, 0, 0, 0, 5'b00000);
        txn(0, 32'h80000000, 32'h00000000, 3'b001, 4'd5, 0, 0, 0, 0, 5'b00000);
        txn(1, 32'h7FC00000, 32'h3F800000, 3'b010, 4'd6, 0, 0, 0, 0, 5'b00000);
        txn(0, 32'h7FC00000, 32'h3F800000, 3'b000, 4'd7, 0, 1, 0, 0, 5'b10000);
        txn(0, 32'h7FC00000, 32'h3F800000, 3'b000, 4'd8, 0, 1, 0, 1, 5'b10000);
        @(negedge clk); fflags_clr = 1'b1;
        @(negedge clk); fflags_clr = 1'b0;
        chk("sticky_clear", 32'(fflags_sticky), 32'd0);
        txn(1, 32'h7FC00000, 32'h3F800000, 3'b101, 4'd9, 0, 0, 1, 0, 5'b00000);
        txn(0, 32'h3F800000, 32'h40000000, 3'b011, 4'd1, 0, 0, 1, 0, 5'b00000);
        txn(0, 32'h00000001, 32'h00000002, 3'b001, 4'hA, 1, 0, 0, 0, 5'b00000);
        txn(1, 32'h80000002, 32'h80000001, 3'b001, 4'hB, 1, 0, 0, 0, 5'b00000);
        txn(0, 32'h40000000, 32'h40000000, 3'b000, 4'hC, 1, 0, 0, 0, 5'b00000);
        txn(1, 32'hBF800000, 32'h3F800000, 3'b001, 4'hD, 1, 0, 0, 0, 5'b00000);
        txn(0, 32'h3F800000, 32'h3F800000, 3'b010, 4'h2, 1, 0, 0, 0, 5'b00000);
        txn(0, 32'h7FA00000, 32'h3F800000, 3'b010, 4'hE, 0, 1, 0, 0, 5'b10000);
        txn(1, 32'hBF800000, 32'hC0000000, 3'b001, 4'hF, 0, 0, 0, 0, 5'b10000);

        // Fairness: both requesters held valid, pointer now favours 0
        @(negedge clk);
        set_req(0, 32'h3F800000, 32'h40000000, 3'b001, 4'd0);
        set_req(1, 32'h3F800000, 32'h40000000, 3'b001, 4'd1);
        req_valid = 2'b11;
        #1;
        g_cnt = 0;
        for (int c = 0; c < 40 && g_cnt < 4; c++) begin
            if (req_ready != 2'b00) begin
                g_id[g_cnt]  = int'(req_ready[1]);
                g_cyc[g_cnt] = c;
                g_cnt++;
            end
            if (g_cnt < 4) begin
                @(negedge clk); #1;
            end
        end
        chk("grant_count", 32'(g_cnt), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < g_cnt) begin
                chk("grant_order", 32'(g_id[k]), 32'(k % 2));
                if (k > 0) chk("grant_gap", 32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
            end
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);

        // Backpressure: response held, no grants while in RESP
        resp_ready = 1'b0;
        set_req(0, 32'h3F800000, 32'h40000000, 3'b001, 4'd9);
        set_req(1, 32'h7FC00000, 32'h3F800000, 3'b000, 4'd10);
        req_valid = 2'b01;
        #1;
        n = 0;
        while (req_ready !== 2'b01 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("bp_hs_timeout", 32'(n >= 20), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_tag", 32'(resp_tag), 32'd9);
            chk("bp_result", 32'(resp_result), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            @(negedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("post_bp_grant", 32'(req_ready), 32'd2);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_tag", 32'(resp_tag), 32'd0);
        chk("mid_rst_result", 32'(resp_result), 32'd0);
        chk("mid_rst_sticky", 32'(fflags_sticky), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_resp_after_rst", 32'(resp_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
